// File: rtl/controle_resfriamento_pkg.sv
// Shared definitions for the motor cooling supervisor: state encoding and counter widths.
package controle_resfriamento_pkg;

  localparam int CNT_W   = 8;
  localparam int RETRY_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_COOL  = 2'd2,
    ST_FAULT = 2'd3
  } estado_t;

endpackage

// File: rtl/controle_resfriamento_detector_borda.sv
// Brings the 1 Hz divider output into clk_in and emits a one-cycle pulse per rising edge.
// The pulse register goes high on the 3rd clk_in edge after the input rises.
// A reset-time high level is not treated as a rising edge: the pulse stays
// masked until the edge-history flop holds a real sample of the input.
module detector_borda
  import controle_resfriamento_pkg::*;
(
  input  logic clk_in,
  input  logic rst,
  input  logic sig_in,
  output logic pulse_out
);

  logic       sync_1;
  logic       sync_2;
  logic       sig_prev;
  logic [2:0] vld;

  // Two-flop synchroniser, edge-history flop and registered rising-edge pulse.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      sync_1    <= 1'b0;
      sync_2    <= 1'b0;
      sig_prev  <= 1'b0;
      vld       <= '0;
      pulse_out <= 1'b0;
    end else begin
      sync_1    <= sig_in;
      sync_2    <= sync_1;
      sig_prev  <= sync_2;
      vld       <= {vld[1:0], 1'b1};
      pulse_out <= sync_2 & ~sig_prev & vld[2];
    end
  end

endmodule

// File: rtl/controle_resfriamento.sv
// Motor drive supervisor: runs the motor on request, limits continuous run time
// and enforces timed cooling after over-temperature or run-limit events.
//
// state | meaning
// IDLE  | motor and fan off, waiting for start
// RUN   | motor on, counting run seconds
// COOL  | motor off, fan on, counting down the cooling interval
// FAULT | repeated over-temperature, latched until fault_clr with temp normal
module controle_resfriamento
  import controle_resfriamento_pkg::*;
#(
  parameter int COOL_SECONDS    = 10,
  parameter int MAX_RUN_SECONDS = 30,
  parameter int MAX_RETRIES     = 3
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       clk_1hz,
  input  logic       start,
  input  logic       stop,
  input  logic       overtemp,
  input  logic       fault_clr,
  output logic       motor_en,
  output logic       fan_en,
  output logic       fault,
  output logic [7:0] seconds_left,
  output logic [1:0] state_o
);

  localparam logic [CNT_W-1:0]   COOL_LOAD  = CNT_W'(COOL_SECONDS);
  localparam logic [CNT_W-1:0]   RUN_LAST   = CNT_W'(MAX_RUN_SECONDS - 1);
  localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(MAX_RETRIES - 1);

  estado_t            state;
  estado_t            state_nx;
  logic [CNT_W-1:0]   run_cnt;
  logic [CNT_W-1:0]   run_nx;
  logic [CNT_W-1:0]   cool_cnt;
  logic [CNT_W-1:0]   cool_nx;
  logic [RETRY_W-1:0] retry_cnt;
  logic [RETRY_W-1:0] retry_nx;
  logic               tick;

  detector_borda u_detector_borda (
    .clk_in    (clk_in),
    .rst       (rst),
    .sig_in    (clk_1hz),
    .pulse_out (tick)
  );

  // Next-state and counter decisions; a transition loads the new state's
  // counter and swallows any coincident tick.
  always_comb begin
    state_nx = state;
    run_nx   = run_cnt;
    cool_nx  = cool_cnt;
    retry_nx = retry_cnt;
    case (state)
      ST_IDLE: begin
        if (start && !stop && !overtemp) begin
          state_nx = ST_RUN;
          run_nx   = '0;
        end else if (start && overtemp) begin
          state_nx = ST_COOL;
          cool_nx  = COOL_LOAD;
          retry_nx = '0;
        end
      end
      ST_RUN: begin
        if (overtemp) begin
          state_nx = ST_COOL;
          cool_nx  = COOL_LOAD;
          retry_nx = '0;
        end else if (stop || !start) begin
          state_nx = ST_IDLE;
        end else if (tick) begin
          if (run_cnt == RUN_LAST) begin
            state_nx = ST_COOL;
            cool_nx  = COOL_LOAD;
            retry_nx = '0;
          end else if (run_cnt != '1) begin
            run_nx = run_cnt + CNT_W'(1);
          end
        end
      end
      ST_COOL: begin
        if (tick) begin
          if (cool_cnt == CNT_W'(1)) begin
            if (!overtemp) begin
              if (start && !stop) begin
                state_nx = ST_RUN;
                run_nx   = '0;
                retry_nx = '0;
              end else begin
                state_nx = ST_IDLE;
              end
            end else if (retry_cnt == RETRY_LAST) begin
              state_nx = ST_FAULT;
            end else begin
              cool_nx = COOL_LOAD;
              if (retry_cnt != '1) retry_nx = retry_cnt + RETRY_W'(1);
            end
          end else if (cool_cnt != '0) begin
            cool_nx = cool_cnt - CNT_W'(1);
          end
        end
      end
      ST_FAULT: begin
        if (fault_clr && !overtemp) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // State, counters and registered outputs derived from the decided next state.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state        <= ST_IDLE;
      run_cnt      <= '0;
      cool_cnt     <= '0;
      retry_cnt    <= '0;
      motor_en     <= 1'b0;
      fan_en       <= 1'b0;
      fault        <= 1'b0;
      seconds_left <= '0;
    end else begin
      state        <= state_nx;
      run_cnt      <= run_nx;
      cool_cnt     <= cool_nx;
      retry_cnt    <= retry_nx;
      motor_en     <= (state_nx == ST_RUN);
      fan_en       <= (state_nx == ST_COOL) || (state_nx == ST_FAULT);
      fault        <= (state_nx == ST_FAULT);
      seconds_left <= (state_nx == ST_COOL) ? cool_nx : '0;
    end
  end

  assign state_o = state;

endmodule

// File: doc/controle_resfriamento.md
Name: controle_resfriamento

Overview:
Supervises the DC motor drive: enables the motor on operator request, enforces a maximum continuous run time, and imposes a timed cooling interval after over-temperature or run-limit events. Time base is the 1 Hz square wave produced by the project clock divider. The block detects its rising edges internally, one pulse per second. It sits between the operator inputs and temperature sensor on one side and the motor driver and fan enable on the other.

Parameters:
COOL_SECONDS, 10, cooling interval in seconds (1..255)
MAX_RUN_SECONDS, 30, maximum continuous run in seconds before forced cooling (1..255)
MAX_RETRIES, 3, consecutive cooling intervals ending with overtemp still high before FAULT (1..15)

Ports:
clk_in  input  1  system clock, 27 MHz
rst  input  1  synchronous reset, active-high
clk_1hz  input  1  1 Hz square wave from the divider (asynchronous domain, 50% duty)
start  input  1  level: operator requests motor run
stop  input  1  level: operator stop, overrides start
overtemp  input  1  level: temperature sensor above threshold (already synchronous)
fault_clr  input  1  one-cycle pulse: acknowledge FAULT
motor_en  output  1  motor driver enable
fan_en  output  1  cooling fan enable
fault  output  1  latched fault indication
seconds_left  output  8  remaining cooling seconds in COOL, else 0
state_o  output  2  current state encoding

Behaviour:
- All logic is on posedge clk_in. rst is sampled synchronously. Reset forces: state IDLE, motor_en=0, fan_en=0, fault=0, seconds_left=0, all counters=0, synchroniser flops=0.
- Tick: clk_1hz passes through a 2-flop synchroniser, then a rising-edge detect produces tick, a one-cycle pulse. tick asserts on the 3rd clk_in edge after the clk_1hz rise. No tick is produced for the first rise seen after reset if clk_1hz is already high.
- States: IDLE=0, RUN=1, COOL=2, FAULT=3. All outputs are registered and reflect the state one cycle after a transition decision.
- IDLE:
  - motor_en=0, fan_en=0.
  - start=1 and stop=0 and overtemp=0 -> RUN; run_cnt cleared.
  - start=1 and overtemp=1 -> COOL; cool_cnt=COOL_SECONDS.
- RUN:
  - motor_en=1. run_cnt increments on tick.
  - Priority: overtemp -> COOL (cool_cnt=COOL_SECONDS, retry_cnt=0); else stop or start=0 -> IDLE; else tick with run_cnt==MAX_RUN_SECONDS-1 -> COOL (cool_cnt=COOL_SECONDS, retry_cnt=0).
- COOL:
  - motor_en=0, fan_en=1. cool_cnt decrements on tick. seconds_left=cool_cnt.
  - stop and start are ignored; a cooling interval cannot be aborted.
  - On tick with cool_cnt==1:
    - overtemp=0 and start=1 and stop=0 -> RUN (run_cnt=0, retry_cnt=0).
    - overtemp=0, otherwise -> IDLE.
    - overtemp=1 and retry_cnt==MAX_RETRIES-1 -> FAULT.
    - overtemp=1, otherwise -> retry_cnt+1, cool_cnt reloaded to COOL_SECONDS, remain in COOL.
- FAULT:
  - motor_en=0, fan_en=1, fault=1.
  - fault_clr=1 and overtemp=0 -> IDLE, fault=0.
  - fault_clr while overtemp=1 is ignored and not remembered.
- Counters saturate, never wrap. run_cnt and cool_cnt are 8 bits; retry_cnt is 4 bits.
- tick coincident with a state-changing input: the transition takes priority, and the tick is consumed by the new state's counter load, not counted.
- rst during any state returns to IDLE on the next edge; the motor stops immediately.

Decomposition:
- Shared package: state encodings IDLE/RUN/COOL/FAULT as 2-bit constants, counter width constant (8), retry width (4).
- One sub-module, detector_borda: 2-flop synchroniser plus rising-edge detect, ports clk_in, rst, sig_in, pulse_out.
- The FSM and counters stay in the top module.

Test Plan:
All scenarios use COOL_SECONDS=3, MAX_RUN_SECONDS=5, MAX_RETRIES=2, and a fast clk_1hz (period 20 clk_in cycles).
1. Reset, then start=1 -> state_o=1, motor_en=1 two cycles after start. After the 5th tick -> state_o=2, fan_en=1, seconds_left=3. After 3 more ticks with start=1 -> back to RUN.
2. RUN, overtemp pulses high for 1 cycle -> COOL, seconds_left=3,2,1 on successive ticks. At the 3rd tick -> IDLE if start=0.
3. overtemp held high through COOL -> reload to 3 after the first interval. After the second interval -> state_o=3, fault=1. fault_clr with overtemp=1 -> stays FAULT. Drop overtemp, then fault_clr -> IDLE, fault=0.
4. RUN, stop=1 -> IDLE next cycle, motor_en=0. stop=1 in COOL -> countdown continues unaffected.
5. rst asserted mid-COOL with seconds_left=2 -> next edge: all outputs 0, state_o=0. clk_1hz high at reset release -> no tick until the next rising edge.
6. overtemp and tick in the same cycle in RUN with run_cnt=4 -> COOL with seconds_left=3; no run-limit double count.
